// File: rtl/adc_capture_ctrl_if.sv
// ADC-side bus of the capture controller: incoming sample stream and RAM port B write signals.
interface adc_capture_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int SAMPLE_WIDTH  = 12
);
    logic                     sample_valid;
    logic [SAMPLE_WIDTH-1:0]  sample_data;
    logic                     adc_wEn;
    logic [ADDRESS_WIDTH-1:0] adc_addr;
    logic [DATA_WIDTH-1:0]    adc_dataIn;

    modport master (
        input  sample_valid,
        input  sample_data,
        output adc_wEn,
        output adc_addr,
        output adc_dataIn
    );

    modport slave (
        output sample_valid,
        output sample_data,
        input  adc_wEn,
        input  adc_addr,
        input  adc_dataIn
    );
endinterface

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: optional threshold trigger, decimation, and one-shot or ring-buffer
// writes into a RAM window. States: IDLE idle | ARMED wait trigger | CAPTURE writing | DONE window full.
module adc_capture_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int SAMPLE_WIDTH  = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [ADDRESS_WIDTH-1:0] cfg_base,
    input  logic [ADDRESS_WIDTH-1:0] cfg_len,
    input  logic [7:0]               cfg_decim,
    input  logic                     cfg_cont,
    input  logic                     cfg_trig_en,
    input  logic [SAMPLE_WIDTH-1:0]  cfg_thresh,
    adc_capture_ctrl_if.master       bus,
    output logic [ADDRESS_WIDTH-1:0] wr_count,
    output logic [15:0]              wrap_count,
    output logic                     busy,
    output logic                     done,
    output logic                     done_pulse
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ONE_A  = ADDRESS_WIDTH'(1);
    localparam logic [7:0]               ONE_D  = 8'd1;
    localparam logic [15:0]              ONE_W  = 16'd1;

    state_t state_q, state_d;

    logic [ADDRESS_WIDTH-1:0] base_q, base_d;
    logic [ADDRESS_WIDTH-1:0] len_q, len_d;
    logic [7:0]               decim_q, decim_d;
    logic                     cont_q, cont_d;
    logic [SAMPLE_WIDTH-1:0]  thresh_q, thresh_d;
    logic [7:0]               dcnt_q, dcnt_d;

    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [ADDRESS_WIDTH-1:0] wr_count_q, wr_count_d;
    logic [15:0]              wrap_q, wrap_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     done_pulse_q, done_pulse_d;

    logic start_ok;
    logic trig_hit;
    logic cap_valid;
    logic wr_sched;
    logic last_slot;

    // A stop in the same cycle suppresses both start acceptance and sample acceptance.
    assign start_ok  = start && !stop && (state_q == S_IDLE || state_q == S_DONE)
                       && (cfg_len != '0);
    assign trig_hit  = (state_q == S_ARMED) && bus.sample_valid && !stop
                       && (bus.sample_data >= thresh_q);
    assign cap_valid = (state_q == S_CAPTURE) && bus.sample_valid && !stop;
    assign wr_sched  = trig_hit || (cap_valid && (dcnt_q == 8'd0));
    assign last_slot = (wr_count_q == (len_q - ONE_A));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            decim_q      <= '0;
            cont_q       <= 1'b0;
            thresh_q     <= '0;
            dcnt_q       <= '0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            wr_count_q   <= '0;
            wrap_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            decim_q      <= decim_d;
            cont_q       <= cont_d;
            thresh_q     <= thresh_d;
            dcnt_q       <= dcnt_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wr_count_q   <= wr_count_d;
            wrap_q       <= wrap_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) state_d = cfg_trig_en ? S_ARMED : S_CAPTURE;
                end
                S_ARMED: begin
                    if (trig_hit) state_d = (last_slot && !cont_q) ? S_DONE : S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (wr_sched && last_slot && !cont_q) state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        base_d     = base_q;
        len_d      = len_q;
        decim_d    = decim_q;
        cont_d     = cont_q;
        thresh_d   = thresh_q;
        dcnt_d     = dcnt_q;
        wen_d      = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_count_d = wr_count_q;
        wrap_d     = wrap_q;

        if (start_ok) begin
            base_d     = cfg_base;
            len_d      = cfg_len;
            decim_d    = cfg_decim;
            cont_d     = cfg_cont;
            thresh_d   = cfg_thresh;
            dcnt_d     = '0;
            wr_count_d = '0;
            wrap_d     = '0;
        end

        // The trigger sample is decimation phase 0, so the next valid sample is phase 1.
        if (trig_hit) begin
            dcnt_d = (decim_q == 8'd0) ? 8'd0 : ONE_D;
        end else if (cap_valid) begin
            dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + ONE_D;
        end

        if (wr_sched) begin
            wen_d  = 1'b1;
            addr_d = base_q + wr_count_q;
            data_d = DATA_WIDTH'(bus.sample_data);
            if (last_slot && cont_q) begin
                wr_count_d = '0;
                wrap_d     = wrap_q + ONE_W;
            end else begin
                wr_count_d = wr_count_q + ONE_A;
            end
        end

        busy_d       = (state_d == S_ARMED) || (state_d == S_CAPTURE);
        done_d       = (state_d == S_DONE);
        done_pulse_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    assign bus.adc_wEn    = wen_q;
    assign bus.adc_addr   = addr_q;
    assign bus.adc_dataIn = data_q;
    assign wr_count       = wr_count_q;
    assign wrap_count     = wrap_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign done_pulse     = done_pulse_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl with hand-computed expectations.
module tb_adc_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [11:0] cfg_base = '0;
    logic [11:0] cfg_len = '0;
    logic [7:0]  cfg_decim = '0;
    logic        cfg_cont = 1'b0;
    logic        cfg_trig_en = 1'b0;
    logic [11:0] cfg_thresh = '0;
    logic [11:0] wr_count;
    logic [15:0] wrap_count;
    logic        busy, done, done_pulse;

    int checks = 0;
    int errors = 0;

    logic [11:0] wa[$];
    logic [31:0] wd[$];
    int          dp_cnt = 0;

    adc_capture_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .SAMPLE_WIDTH(12)) bus ();

    adc_capture_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .SAMPLE_WIDTH(12)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .cfg_decim  (cfg_decim),
        .cfg_cont   (cfg_cont),
        .cfg_trig_en(cfg_trig_en),
        .cfg_thresh (cfg_thresh),
        .bus        (bus),
        .wr_count   (wr_count),
        .wrap_count (wrap_count),
        .busy       (busy),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.adc_wEn === 1'b1) begin
            wa.push_back(bus.adc_addr);
            wd.push_back(bus.adc_dataIn);
        end
        if (done_pulse === 1'b1) dp_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] d);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic set_cfg(input logic [11:0] b, input logic [11:0] l, input logic [7:0] dec,
                           input logic c, input logic te, input logic [11:0] th);
        cfg_base = b; cfg_len = l; cfg_decim = dec;
        cfg_cont = c; cfg_trig_en = te; cfg_thresh = th;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        dp_cnt = 0;
    endtask

    task automatic test_reset();
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.adc_wEn, bus.adc_addr, bus.adc_dataIn, wr_count, wrap_count, busy, done, done_pulse} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wEn=%0h addr=%0h data=%0h wc=%0h wrap=%0h busy=%0h done=%0h dp=%0h required all 0",
                     bus.adc_wEn, bus.adc_addr, bus.adc_dataIn, wr_count, wrap_count, busy, done, done_pulse);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_one_shot();
        clear_log();
        set_cfg(12'h100, 12'd4, 8'd0, 1'b0, 1'b0, 12'h000);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL oneshot_busy: got %0h required 1", busy); end
        send(12'd1);
        checks++;
        if (bus.adc_wEn !== 1'b1 || bus.adc_addr !== 12'h100) begin
            errors++;
            $display("FAIL oneshot_latency: got wEn=%0h addr=%0h required wEn=1 addr=100", bus.adc_wEn, bus.adc_addr);
        end
        send(12'd2);
        send(12'd3);
        send(12'd4);
        checks++;
        if (done_pulse !== 1'b1 || bus.adc_wEn !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_final_edge: got dp=%0h wEn=%0h done=%0h required 1 1 1", done_pulse, bus.adc_wEn, done);
        end
        send(12'd5);
        send(12'd6);
        tick();
        tick();
        checks++;
        if (wa.size() != 4) begin errors++; $display("FAIL oneshot_count: got %0d writes required 4", wa.size()); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== 12'(12'h100 + i) || wd[i] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL oneshot_write%0d: got addr=%0h data=%0h required addr=%0h data=%0h",
                         i, wa[i], wd[i], 12'h100 + i, i + 1);
            end
        end
        checks++;
        if (dp_cnt != 1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_done: got pulses=%0d done=%0h busy=%0h required 1 1 0", dp_cnt, done, busy);
        end
    endtask

    task automatic test_ring_wrap();
        logic [11:0] exp_a [7];
        exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'hFFE, 12'hFFF, 12'h000, 12'hFFE};
        clear_log();
        set_cfg(12'hFFE, 12'd3, 8'd0, 1'b1, 1'b0, 12'h000);
        pulse_start();
        for (int i = 0; i < 7; i++) send(12'(12'h20 + i));
        tick();
        checks++;
        if (wa.size() != 7) begin errors++; $display("FAIL ring_count: got %0d writes required 7", wa.size()); end
        for (int i = 0; i < 7 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== exp_a[i] || wd[i] !== 32'(12'h20 + i)) begin
                errors++;
                $display("FAIL ring_write%0d: got addr=%0h data=%0h required addr=%0h data=%0h",
                         i, wa[i], wd[i], exp_a[i], 12'h20 + i);
            end
        end
        checks++;
        if (wrap_count !== 16'd2 || wr_count !== 12'd1 || busy !== 1'b1 || dp_cnt != 0) begin
            errors++;
            $display("FAIL ring_status: got wrap=%0d wc=%0d busy=%0h pulses=%0d required 2 1 1 0",
                     wrap_count, wr_count, busy, dp_cnt);
        end
        pulse_stop();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ring_stop: got busy=%0h done=%0h required 0 0", busy, done);
        end
    endtask

    task automatic test_trigger_decim();
        clear_log();
        set_cfg(12'h300, 12'd8, 8'd2, 1'b0, 1'b1, 12'h800);
        pulse_start();
        send(12'h100);
        checks++;
        if (busy !== 1'b1 || bus.adc_wEn !== 1'b0) begin
            errors++;
            $display("FAIL trig_armed: got busy=%0h wEn=%0h required 1 0", busy, bus.adc_wEn);
        end
        send(12'h900);
        send(12'h010);
        tick();
        send(12'h020);
        send(12'h040);
        tick();
        tick();
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL trig_count: got %0d writes required 2", wa.size());
        end else begin
            checks++;
            if (wd[0] !== 32'h900 || wa[0] !== 12'h300 || wd[1] !== 32'h040 || wa[1] !== 12'h301) begin
                errors++;
                $display("FAIL trig_data: got %0h@%0h %0h@%0h required 900@300 40@301", wd[0], wa[0], wd[1], wa[1]);
            end
        end
        pulse_stop();
    endtask

    task automatic test_thresh_boundary();
        clear_log();
        set_cfg(12'h050, 12'd1, 8'd0, 1'b0, 1'b1, 12'h800);
        pulse_start();
        send(12'h7FF);
        checks++;
        if (bus.adc_wEn !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL thresh_below: got wEn=%0h busy=%0h required 0 1", bus.adc_wEn, busy);
        end
        send(12'h800);
        checks++;
        if (bus.adc_wEn !== 1'b1 || bus.adc_dataIn !== 32'h800 || bus.adc_addr !== 12'h050
            || done_pulse !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL thresh_equal_len1: got wEn=%0h data=%0h addr=%0h dp=%0h busy=%0h required 1 800 50 1 0",
                     bus.adc_wEn, bus.adc_dataIn, bus.adc_addr, done_pulse, busy);
        end
        pulse_stop();
    endtask

    task automatic test_control_races();
        clear_log();
        set_cfg(12'h200, 12'd4, 8'd0, 1'b0, 1'b0, 12'h000);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        send(12'h0AA);
        tick();
        checks++;
        if (busy !== 1'b0 || wa.size() != 0) begin
            errors++;
            $display("FAIL race_start_stop: got busy=%0h writes=%0d required 0 0", busy, wa.size());
        end
        pulse_start();
        send(12'h001);
        send(12'h002);
        set_cfg(12'h300, 12'd2, 8'd0, 1'b0, 1'b0, 12'h000);
        pulse_start();
        send(12'h003);
        tick();
        checks++;
        if (wa.size() != 3 || wr_count !== 12'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL race_start_busy: got writes=%0d wc=%0d busy=%0h required 3 3 1", wa.size(), wr_count, busy);
        end else begin
            checks++;
            if (wa[2] !== 12'h202) begin
                errors++;
                $display("FAIL race_start_busy_addr: got %0h required 202", wa[2]);
            end
        end
        pulse_stop();
        set_cfg(12'h100, 12'd0, 8'd0, 1'b0, 1'b0, 12'h000);
        pulse_start();
        send(12'h004);
        checks++;
        if (busy !== 1'b0 || bus.adc_wEn !== 1'b0) begin
            errors++;
            $display("FAIL race_len0: got busy=%0h wEn=%0h required 0 0", busy, bus.adc_wEn);
        end
    endtask

    task automatic test_reset_mid_capture();
        clear_log();
        set_cfg(12'h040, 12'd8, 8'd0, 1'b0, 1'b0, 12'h000);
        pulse_start();
        send(12'h011);
        send(12'h012);
        bus.sample_valid = 1'b1;
        bus.sample_data  = 12'h013;
        reset_n = 1'b0;
        tick();
        bus.sample_valid = 1'b0;
        checks++;
        if ({bus.adc_wEn, bus.adc_addr, bus.adc_dataIn, wr_count, wrap_count, busy, done, done_pulse} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got wEn=%0h addr=%0h data=%0h wc=%0h busy=%0h required all 0",
                     bus.adc_wEn, bus.adc_addr, bus.adc_dataIn, wr_count, busy);
        end
        reset_n = 1'b1;
        send(12'h014);
        tick();
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL midreset_nowrite: got %0d writes required 2", wa.size());
        end
        pulse_start();
        send(12'h015);
        checks++;
        if (bus.adc_wEn !== 1'b1 || bus.adc_addr !== 12'h040 || bus.adc_dataIn !== 32'h015) begin
            errors++;
            $display("FAIL midreset_restart: got wEn=%0h addr=%0h data=%0h required 1 40 15",
                     bus.adc_wEn, bus.adc_addr, bus.adc_dataIn);
        end
        pulse_stop();
    endtask

    task automatic test_stop_with_sample();
        clear_log();
        set_cfg(12'h500, 12'd8, 8'd0, 1'b0, 1'b0, 12'h000);
        pulse_start();
        bus.sample_valid = 1'b1;
        bus.sample_data  = 12'h0A1;
        tick();
        bus.sample_data  = 12'h0A2;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        bus.sample_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.adc_wEn !== 1'b0) begin
            errors++;
            $display("FAIL stop_sample_state: got busy=%0h wEn=%0h required 0 0", busy, bus.adc_wEn);
        end
        tick();
        checks++;
        if (wa.size() != 1) begin
            errors++;
            $display("FAIL stop_sample_writes: got %0d writes required 1", wa.size());
        end else begin
            checks++;
            if (wd[0] !== 32'h0A1 || wa[0] !== 12'h500) begin
                errors++;
                $display("FAIL stop_sample_prev: got %0h@%0h required a1@500", wd[0], wa[0]);
            end
        end
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        test_reset();
        test_one_shot();
        test_ring_wrap();
        test_trigger_decim();
        test_thresh_boundary();
        test_control_races();
        test_reset_mid_capture();
        test_stop_with_sample();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
